key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 134 +++++++++++++
 tb/tb_key_debounce.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Pushbutton debouncer: synchronizes an active-low raw key, qualifies level
// changes over DEBOUNCE_CYCLES samples, and emits press/release/long-hold strobes.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               key_n,
  output logic               pressed,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_pulse,
  output logic [COUNT_W-1:0] press_count
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               pressed_q, pressed_d;
  logic               press_pulse_q, press_pulse_d;
  logic               release_pulse_q, release_pulse_d;
  logic               long_pulse_q, long_pulse_d;
  logic [COUNT_W-1:0] press_count_q, press_count_d;
  logic               key_c;

  assign key_c = ~sync2_q;

  // Next-state, counters and strobes
  always_comb begin
    sync1_d         = key_n;
    sync2_d         = sync1_q;
    state_d         = state_q;
    cnt_d           = cnt_q;
    hold_d          = hold_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;
    press_count_d   = press_count_q + COUNT_W'(press_pulse_q);

    case (state_q)
      IDLE: begin
        if (key_c) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_c) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d       = PRESSED;
          press_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!key_c) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_c) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d         = IDLE;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Hold timer saturates at LONG_CYCLES so the long strobe fires once per press
    if (press_pulse_d) begin
      hold_d = '0;
    end else if (((state_q == PRESSED) || (state_q == RELEASE_WAIT)) &&
                 (hold_q != HOLD_W'(LONG_CYCLES))) begin
      hold_d = hold_q + HOLD_W'(1);
      if ((hold_q == HOLD_W'(LONG_CYCLES - 1)) && !release_pulse_d) begin
        long_pulse_d = 1'b1;
      end
    end

    pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      state_q         <= IDLE;
      cnt_q           <= '0;
      hold_q          <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      press_count_q   <= '0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      hold_q          <= hold_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      press_count_q   <= press_count_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;
  assign press_count   = press_count_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: a table of press lengths plus hand-written corner sequences;
// expected strobes (kind, edge number) are queued at stimulus time and matched as they appear.
module tb_key_debounce;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 16;
  localparam int unsigned CW   = 8;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          key_n = 1'b1;
  logic          pressed, press_pulse, release_pulse, long_pulse;
  logic [CW-1:0] press_count;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .COUNT_W        (CW)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .key_n        (key_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int n_press = 0, n_rel = 0, n_long = 0;
  logic [CW-1:0] exp_count = '0;

  typedef struct { int kind; int at; } ev_t;
  ev_t exp_q[$];

  typedef struct { int hold; int gap; bit ep; bit el; } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_pulse_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_edge", cyc, e.at);
    end
  endtask

  // Strobe monitor: every observed strobe must match the head of the queue
  always @(negedge clk) begin
    if (!reset) begin
      if (press_pulse && release_pulse) chk("press_release_overlap", 1, 0);
      if (long_pulse && release_pulse) chk("long_release_overlap", 1, 0);
      if (press_pulse) begin n_press++; pop_check(K_PRESS); end
      if (long_pulse) begin n_long++; pop_check(K_LONG); end
      if (release_pulse) begin n_rel++; pop_check(K_REL); end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Hold key_n low for 'hold' edges starting at edge n, then high for the gap
  task automatic run_vec(input int hold, input int gap, input bit ep, input bit el);
    int n;
    @(negedge clk);
    key_n = 1'b0;
    n = cyc + 1;
    if (ep) begin
      push(K_PRESS, n + 2 + int'(DEB));
      if (el) push(K_LONG, n + 2 + int'(DEB) + int'(LONG));
      push(K_REL, n + hold + 2 + int'(DEB));
      exp_count++;
    end
    if (ep && hold >= 7) begin
      wait_until(n + 5);
      chk("pressed_before_latency", int'(pressed), 0);
      wait_until(n + 6);
      chk("pressed_at_latency", int'(pressed), 1);
    end
    wait_until(n + hold - 1);
    key_n = 1'b1;
    if (ep) begin
      wait_until(n + hold + 5);
      chk("pressed_before_release", int'(pressed), 1);
      wait_until(n + hold + 6);
      chk("pressed_after_release", int'(pressed), 0);
    end
    wait_until(n + hold + gap);
    chk("press_count", int'(press_count), int'(exp_count));
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got edge %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int n, p0, r0;
    logic [CW-1:0] c0;

    vecs[0] = '{1, 8, 1'b0, 1'b0};
    vecs[1] = '{3, 8, 1'b0, 1'b0};
    vecs[2] = '{5, 8, 1'b1, 1'b0};
    vecs[3] = '{10, 8, 1'b1, 1'b0};
    vecs[4] = '{17, 8, 1'b1, 1'b1};
    vecs[5] = '{30, 8, 1'b1, 1'b1};
    vecs[6] = '{8, 8, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_pressed", int'(pressed), 0);
    chk("reset_press_pulse", int'(press_pulse), 0);
    chk("reset_release_pulse", int'(release_pulse), 0);
    chk("reset_long_pulse", int'(long_pulse), 0);
    chk("reset_press_count", int'(press_count), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i].hold, vecs[i].gap, vecs[i].ep, vecs[i].el);
    end

    // Key chatter: two low, two high, repeated; must never qualify
    p0 = n_press;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); key_n = 1'b0;
      @(negedge clk);
      @(negedge clk); key_n = 1'b1;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("chatter_pressed", int'(pressed), 0);
    chk("chatter_no_press", n_press - p0, 0);
    chk("chatter_count", int'(press_count), int'(exp_count));

    // Single-sample release bounce while held
    @(negedge clk);
    key_n = 1'b0;
    n = cyc + 1;
    push(K_PRESS, n + 6);
    exp_count++;
    wait_until(n + 10);
    key_n = 1'b1;
    wait_until(n + 11);
    key_n = 1'b0;
    wait_until(n + 14);
    chk("bounce_still_pressed", int'(pressed), 1);
    key_n = 1'b1;
    push(K_REL, n + 21);
    wait_until(n + 20);
    chk("bounce_pressed_in_release_wait", int'(pressed), 1);
    wait_until(n + 21);
    chk("bounce_released", int'(pressed), 0);
    wait_until(n + 30);
    chk("bounce_count", int'(press_count), int'(exp_count));
    chk("bounce_queue_drained", exp_q.size(), 0);

    // Reset two cycles after press_pulse with the key held
    @(negedge clk);
    key_n = 1'b0;
    n = cyc + 1;
    push(K_PRESS, n + 6);
    exp_count++;
    wait_until(n + 7);
    chk("pre_reset_count", int'(press_count), int'(exp_count));
    reset = 1'b1;
    for (int k = 8; k <= 10; k++) begin
      wait_until(n + k);
      chk("in_reset_pressed", int'(pressed), 0);
      chk("in_reset_count", int'(press_count), 0);
      chk("in_reset_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
    end
    reset = 1'b0;
    exp_count = 8'd1;
    push(K_PRESS, n + 17);
    wait_until(n + 16);
    chk("requal_pressed_early", int'(pressed), 0);
    wait_until(n + 17);
    chk("requal_pressed", int'(pressed), 1);
    wait_until(n + 19);
    chk("requal_count", int'(press_count), 1);
    key_n = 1'b1;
    push(K_REL, n + 26);
    wait_until(n + 30);
    chk("reset_seq_queue_drained", exp_q.size(), 0);

    // 256 presses wrap the 8-bit counter back to its start value
    p0 = n_press;
    r0 = n_rel;
    c0 = press_count;
    for (int i = 0; i < 256; i++) run_vec(6, 8, 1'b1, 1'b0);
    chk("wrap_press_pulses", n_press - p0, 256);
    chk("wrap_release_pulses", n_rel - r0, 256);
    chk("wrap_count", int'(press_count), int'(c0));

    chk("total_long_pulses", n_long, 2);
    chk("final_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
